seven_segment_reader: RTL
=========================

// Module: seven_segment_reader
// PURPOSE
//  Receive side of the multiplexed seven-segment display interface: samples active-low
//  segment lines and active-low digit anodes, waits for each digit to hold stable, and
//  decodes each pattern back to a 4-bit value.
//  Builds a full frame of NUM_DIGITS values and hands it off over a valid/ready handshake.
//  Used for on-chip display loopback self-test and for bench readback of the display path.
// PARAMETERS
//  NUM_DIGITS     4  number of multiplexed digits (anode lines), >=1
//  STABLE_CYCLES  4  consecutive identical synced samples required before a capture, >=2
// PORTS
//  clk          in   1             system clock
//  rst_n        in   1             asynchronous active-low reset
//  seg_in       in   7             segment lines, active-low, bit6=g..bit0=a
//  an_in        in   NUM_DIGITS    anode selects, active-low, bit i = digit i
//  frame_data   out  4*NUM_DIGITS  decoded frame, digit i at [4i+3:4i]
//  frame_err    out  NUM_DIGITS    per-digit illegal-pattern flag for frame_data
//  frame_valid  out  1             frame_data/frame_err hold a complete, unconsumed frame
//  frame_ready  in   1             consumer accepts the frame when high with frame_valid
//  overrun      out  1             sticky: a frame completed while the previous one was unconsumed
// BEHAVIOUR
//  Reset: frame_data=0, frame_err=0, frame_valid=0, overrun=0; sync flops, stable counter,
//   seen mask and slot storage all cleared; FSM=COLLECT. rst_n asserted mid-frame discards all data.
//  Input sync: seg_in and an_in each pass through 2 flops; all logic below uses synced values.
//  Anode legality: exactly one synced anode bit low. Otherwise (none or several low):
//   stable counter reset to 0, no capture.
//  Stability: if the synced {seg,an} equals the previous cycle's value and the anode is legal,
//   the counter increments and saturates at STABLE_CYCLES-1; on any change it resets to 0.
//   Capture fires once, on the cycle the counter goes STABLE_CYCLES-2 -> STABLE_CYCLES-1.
//   A held pattern never re-fires.
//  Decode on capture (seg, active-low):
//   1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5,
//   0000010->6, 1111000->7, 0000000->8, 0010000->9, 1111111->F (blank, err=0).
//   Any other pattern ->E with err=1.
//   The value and err are written to slot i and seen[i] is set. Recapturing a seen slot overwrites it.
//  Latency: pin change -> slot written after 2 + STABLE_CYCLES clocks.
//  FSM states:
//   COLLECT  frame_valid=0. When seen becomes all-ones (including the capture cycle itself),
//            the next edge copies slots to frame_data/frame_err, clears seen, -> PRESENT.
//   PRESENT  frame_valid=1, outputs frozen; capture continues into slots.
//            frame_ready=1 -> frame_valid=0 next cycle, -> COLLECT.
//   Simultaneous events in PRESENT (frame_ready and completion of a new frame in the same cycle):
//    new frame is copied out, stay in PRESENT, frame_valid stays 1, no overrun.
//   New frame completes in PRESENT without frame_ready: overrun<=1, seen cleared, new frame
//    dropped, outputs unchanged.
//  overrun clears only on reset.
//  frame_ready is ignored while frame_valid=0.
//  All outputs registered; no combinational path from inputs to outputs.
// TESTING
//  1. Scan digits 3,2,1,0 showing 1,2,3,4, 8 clocks per digit, frame_ready=1
//     -> one frame_valid pulse; frame_data=16'h1234, frame_err=0.
//  2. Hold digit0 on pattern 0010010 for 3 cycles, then change it (STABLE_CYCLES=4)
//     -> no capture. Hold it for 4 cycles -> slot0=5, captured exactly once.
//  3. Digit2 shows 1111111 and digit1 shows 0101010 -> slot2=F with err=0; slot1=E with err=1
//     (frame_err=4'b0010).
//  4. an_in=4'b0000 or 4'b1111 for 20 cycles -> no captures; seen unchanged; frame_valid stays 0.
//  5. frame_ready=0; two full frames scanned -> first frame held, overrun=1, frame_data unchanged.
//     frame_ready=1 -> frame_valid drops next cycle.
//  6. Assert rst_n=0 after 3 of 4 digits captured, release, then scan 4 digits
//     -> frame holds only the post-reset values; all outputs 0 during reset.

Source files
------------

// File: rtl/seven_segment_reader.sv
// seven_segment_reader: receive side of a multiplexed active-low seven-segment
// display. Synchronises the segment and anode lines, waits for each digit to
// hold steady, decodes it back to a nibble, and presents a full frame of
// NUM_DIGITS values on a valid/ready handshake.
//
// Handshake: frame_valid is asserted while frame_data/frame_err hold an
// unconsumed frame; a transfer happens on a clock edge where frame_valid and
// frame_ready are both high. frame_ready has no effect while frame_valid is low.
module seven_segment_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] frame_data,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overrun
);

  // Counter only needs to reach STABLE_CYCLES-1.
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_FIRE = CW'(STABLE_CYCLES - 2);

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Synchronisers and previous-sample registers.
  logic [6:0]            seg_s1, seg_s2, seg_prev;
  logic [NUM_DIGITS-1:0] an_s1, an_s2, an_prev;

  // Stability tracking.
  logic [CW-1:0]         cnt_q;
  logic [NUM_DIGITS-1:0] sel;
  logic                  legal;
  logic                  same;
  logic                  capture;
  logic [4:0]            dec;

  // Slot storage and frame assembly.
  logic [3:0]              slot_val_q [NUM_DIGITS];
  logic [3:0]              slot_val_n [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   slot_err_q, slot_err_n;
  logic [NUM_DIGITS-1:0]   seen_q, seen_n;
  logic                    complete;
  logic [4*NUM_DIGITS-1:0] frame_data_n;

  // FSM.
  state_t state_q, state_n;
  logic   load_frame;
  logic   set_overrun;

  // Decode an active-low pattern into {err, value}; blank is F without error.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    case (s)
      7'b1000000: return 5'h00;
      7'b1111001: return 5'h01;
      7'b0100100: return 5'h02;
      7'b0110000: return 5'h03;
      7'b0011001: return 5'h04;
      7'b0010010: return 5'h05;
      7'b0000010: return 5'h06;
      7'b1111000: return 5'h07;
      7'b0000000: return 5'h08;
      7'b0010000: return 5'h09;
      7'b1111111: return 5'h0F;
      default:    return 5'h1E;
    endcase
  endfunction

  // Two-flop synchronisers plus a copy of the last synced sample for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1   <= '0;
      seg_s2   <= '0;
      seg_prev <= '0;
      an_s1    <= '0;
      an_s2    <= '0;
      an_prev  <= '0;
    end else begin
      seg_s1   <= seg_in;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
      an_s1    <= an_in;
      an_s2    <= an_s1;
      an_prev  <= an_s2;
    end
  end

  // Anode legality (exactly one low), sample equality and capture strobe.
  always_comb begin
    sel     = ~an_s2;
    legal   = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
    same    = (seg_s2 == seg_prev) && (an_s2 == an_prev);
    capture = legal && same && (cnt_q == CNT_FIRE);
    dec     = decode_seg(seg_s2);
  end

  // Saturating stability counter; any change or illegal anode restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!legal || !same) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Next slot contents and seen mask, including this cycle's capture so a
  // frame completing now is copied out with its final digit.
  always_comb begin
    slot_err_n = slot_err_q;
    seen_n     = seen_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      slot_val_n[i] = slot_val_q[i];
      if (capture && sel[i]) begin
        slot_val_n[i] = dec[3:0];
        slot_err_n[i] = dec[4];
        seen_n[i]     = 1'b1;
      end
    end
    complete     = &seen_n;
    frame_data_n = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      frame_data_n[4*i +: 4] = slot_val_n[i];
    end
  end

  // Slot storage and seen mask; a completed frame always clears seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        slot_val_q[i] <= '0;
      end
      slot_err_q <= '0;
      seen_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        slot_val_q[i] <= slot_val_n[i];
      end
      slot_err_q <= slot_err_n;
      seen_q     <= complete ? '0 : seen_n;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_n;
    end
  end

  // FSM next state: a frame completing alongside a consume keeps us in PRESENT.
  always_comb begin
    state_n = state_q;
    case (state_q)
      COLLECT: if (complete) state_n = PRESENT;
      PRESENT: if (frame_ready && !complete) state_n = COLLECT;
      default: state_n = COLLECT;
    endcase
  end

  // FSM control outputs: load a new frame or flag an overrun.
  always_comb begin
    load_frame  = 1'b0;
    set_overrun = 1'b0;
    case (state_q)
      COLLECT: load_frame = complete;
      PRESENT: begin
        load_frame  = complete && frame_ready;
        set_overrun = complete && !frame_ready;
      end
      default: ;
    endcase
  end

  // Output frame registers and sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_data <= '0;
      frame_err  <= '0;
      overrun    <= 1'b0;
    end else begin
      if (load_frame) begin
        frame_data <= frame_data_n;
        frame_err  <= slot_err_n;
      end
      if (set_overrun) begin
        overrun <= 1'b1;
      end
    end
  end

  assign frame_valid = (state_q == PRESENT);

endmodule
